// File: rtl/pms_pkg.sv
// rtl/pms_pkg.sv - shared opcodes, state encoding and decode helper for pms_sequencer
// Purpose: opcode constants (ir[15:12]), the 3-bit FSM state type and the
// two-word opcode classifier used by DECODE.
// Ports: none (package).
package pms_pkg;

  localparam logic [3:0] OP_HALT  = 4'd0;
  localparam logic [3:0] OP_ALU   = 4'd1;
  localparam logic [3:0] OP_ALUI  = 4'd2;
  localparam logic [3:0] OP_LOAD  = 4'd3;
  localparam logic [3:0] OP_STORE = 4'd4;
  localparam logic [3:0] OP_BR    = 4'd5;
  localparam logic [3:0] OP_JAL   = 4'd6;
  localparam logic [3:0] OP_RET   = 4'd7;

  typedef enum logic [2:0] {
    ST_IDLE, ST_FETCH, ST_DECODE, ST_IMM, ST_EXEC, ST_MEM, ST_WB, ST_HALTED
  } state_t;

  // Opcodes that carry an immediate word at PC+1.
  function automatic logic is_two_word(input logic [3:0] op);
    return op inside {OP_ALUI, OP_LOAD, OP_STORE, OP_BR, OP_JAL};
  endfunction

endpackage

// File: rtl/pms_if.sv
// rtl/pms_if.sv - control bundle between the sequencer and the PC/memory datapath
// Purpose: groups the sequencer inputs (start, ir, zero_flag, mem_ack) and all
// PC-system, memory-system and status outputs.
// Ports: master = sequencer side (drives controls/status), slave = datapath side.
interface pms_if #(
  parameter int CNT_W = 16
);
  logic             start;
  logic [15:0]      ir;
  logic             zero_flag;
  logic             mem_ack;
  logic             writePC, writeRA, PCsrc, ImRPC, restore, conditionalBop;
  logic             Memsrc, MemR1, MemR2, MemW1, MemW2;
  logic             alu_go, reg_write, busy, instr_done, illegal_op, bus_err;
  logic [CNT_W-1:0] retired;

  modport master (
    input  start, ir, zero_flag, mem_ack,
    output writePC, writeRA, PCsrc, ImRPC, restore, conditionalBop,
    output Memsrc, MemR1, MemR2, MemW1, MemW2,
    output alu_go, reg_write, busy, instr_done, illegal_op, bus_err, retired
  );

  modport slave (
    output start, ir, zero_flag, mem_ack,
    input  writePC, writeRA, PCsrc, ImRPC, restore, conditionalBop,
    input  Memsrc, MemR1, MemR2, MemW1, MemW2,
    input  alu_go, reg_write, busy, instr_done, illegal_op, bus_err, retired
  );

endinterface

// File: rtl/pms_mem_timer.sv
// rtl/pms_mem_timer.sv - wait-cycle counter bounding the MEM data-port handshake
// Purpose: counts MEM cycles spent without mem_ack.
// Ports: clk, reset_n (sync active-low), clear (restart count), enable (count
// this cycle), expired (this cycle is the MEM_TIMEOUT-th unacknowledged wait).
module pms_mem_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // Flagged one count early so the FSM can leave MEM on the same edge
  // the count reaches MEM_TIMEOUT.
  assign expired = (count == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/pms_sequencer.sv
// rtl/pms_sequencer.sv - multicycle fetch/decode/execute/mem/writeback control FSM
// Purpose: drives PC-system and memory-system strobes from ir[15:12], times the
// data-port handshake, flags bus errors and counts retired instructions.
// Ports: clk, reset_n (sync active-low), bus (pms_if.master: start, ir,
// zero_flag, mem_ack in; control strobes, busy, instr_done, illegal_op,
// bus_err, retired out).
module pms_sequencer
  import pms_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic     clk,
  input  logic     reset_n,
  pms_if.master    bus
);

  state_t           state, state_next;
  logic [3:0]       op;
  logic [3:0]       dec_op;
  logic             bus_err_q;
  logic [CNT_W-1:0] retired_q;
  logic             set_bus_err;
  logic             timer_clear, timer_en, timer_expired;
  logic             unused_ir_bits;

  assign dec_op         = bus.ir[15:12];
  assign unused_ir_bits = ^bus.ir[11:0];

  pms_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      op        <= OP_HALT;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state <= state_next;
      if (state == ST_DECODE) op <= dec_op;
      if (set_bus_err) bus_err_q <= 1'b1;
      if (bus.instr_done) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_next         = state;
    set_bus_err        = 1'b0;
    timer_clear        = 1'b0;
    timer_en           = 1'b0;
    bus.writePC        = 1'b0;
    bus.writeRA        = 1'b0;
    bus.PCsrc          = 1'b0;
    bus.ImRPC          = 1'b0;
    bus.restore        = 1'b0;
    bus.conditionalBop = 1'b0;
    bus.Memsrc         = 1'b0;
    bus.MemR1          = 1'b0;
    bus.MemR2          = 1'b0;
    bus.MemW2          = 1'b0;
    bus.alu_go         = 1'b0;
    bus.reg_write      = 1'b0;
    bus.instr_done     = 1'b0;
    bus.illegal_op     = 1'b0;
    case (state)
      ST_IDLE: if (bus.start) state_next = ST_FETCH;
      ST_FETCH: begin
        bus.MemR1  = 1'b1;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        // op is not yet latched here, so decode straight from ir.
        if (is_two_word(dec_op)) begin
          state_next = ST_IMM;
        end else if (dec_op == OP_ALU || dec_op == OP_RET) begin
          state_next = ST_EXEC;
        end else if (dec_op == OP_HALT) begin
          bus.instr_done = 1'b1;
          state_next     = ST_HALTED;
        end else begin
          bus.illegal_op = 1'b1;
          bus.writePC    = 1'b1;
          bus.instr_done = 1'b1;
          state_next     = ST_FETCH;
        end
      end
      ST_IMM: begin
        bus.MemR2  = 1'b1;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = ST_FETCH;
        case (op)
          OP_ALU, OP_ALUI: begin
            bus.alu_go     = 1'b1;
            bus.reg_write  = 1'b1;
            bus.writePC    = 1'b1;
            bus.PCsrc      = (op == OP_ALUI);
            bus.instr_done = 1'b1;
          end
          OP_BR: begin
            bus.writePC        = 1'b1;
            bus.PCsrc          = 1'b1;
            bus.ImRPC          = 1'b1;
            bus.conditionalBop = bus.zero_flag;
            bus.instr_done     = 1'b1;
          end
          OP_JAL: begin
            bus.writeRA    = 1'b1;
            bus.writePC    = 1'b1;
            bus.ImRPC      = 1'b1;
            bus.instr_done = 1'b1;
          end
          OP_RET: begin
            bus.restore    = 1'b1;
            bus.writePC    = 1'b1;
            bus.instr_done = 1'b1;
          end
          OP_LOAD, OP_STORE: begin
            bus.alu_go  = 1'b1;
            timer_clear = 1'b1;
            state_next  = ST_MEM;
          end
          default: state_next = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        bus.Memsrc = 1'b1;
        bus.MemR2  = (op == OP_LOAD);
        bus.MemW2  = (op == OP_STORE);
        // An ack arriving in the expiry cycle still completes the access.
        if (bus.mem_ack) begin
          if (op == OP_LOAD) begin
            state_next = ST_WB;
          end else begin
            bus.writePC    = 1'b1;
            bus.PCsrc      = 1'b1;
            bus.instr_done = 1'b1;
            state_next     = ST_FETCH;
          end
        end else begin
          timer_en = 1'b1;
          if (timer_expired) begin
            set_bus_err = 1'b1;
            state_next  = ST_HALTED;
          end
        end
      end
      ST_WB: begin
        bus.reg_write  = 1'b1;
        bus.writePC    = 1'b1;
        bus.PCsrc      = 1'b1;
        bus.instr_done = 1'b1;
        state_next     = ST_FETCH;
      end
      ST_HALTED: state_next = ST_HALTED;
    endcase
  end

  assign bus.MemW1   = 1'b0;
  assign bus.busy    = (state != ST_IDLE) && (state != ST_HALTED);
  assign bus.bus_err = bus_err_q;
  assign bus.retired = retired_q;

endmodule
